ysyx_2022040010_mem_arbiter: RTL

//   Shares the single downstream memory bus (AXI bridge front end) among three requesters:

---
 rtl/ysyx_2022040010_mem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/ysyx_2022040010_mem_arbiter.sv
// ysyx_2022040010_mem_arbiter: shares one memory bus among icache, dcache and uncached requesters
// Fixed priority uc > dc > ic by default; define ARB_RR_EN for round-robin arbitration.
module ysyx_2022040010_mem_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ic_req,
  input  logic            ic_we,
  input  logic [AW-1:0]   ic_addr,
  input  logic [DW-1:0]   ic_wdata,
  input  logic [DW/8-1:0] ic_wsel,
  output logic            ic_done,
  input  logic            dc_req,
  input  logic            dc_we,
  input  logic [AW-1:0]   dc_addr,
  input  logic [DW-1:0]   dc_wdata,
  input  logic [DW/8-1:0] dc_wsel,
  output logic            dc_done,
  input  logic            uc_req,
  input  logic            uc_we,
  input  logic [AW-1:0]   uc_addr,
  input  logic [DW-1:0]   uc_wdata,
  input  logic [DW/8-1:0] uc_wsel,
  output logic            uc_done,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic            bus_e,
  output logic            bus_we,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_wsel,
  input  logic            bus_done,
  input  logic [DW-1:0]   bus_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state;
  logic [2:0]      req, win, grant;
  logic [CW-1:0]   cnt;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [DW/8-1:0] sel_wsel;
  assign req = {uc_req, dc_req, ic_req};
`ifdef ARB_RR_EN
  logic [2:0] ptr;
  // the requester after ptr in the uc->dc->ic->uc rotation has top priority
  always_comb
    win = ptr[2] ? (req[1] ? 3'b010 : req[0] ? 3'b001 : req[2] ? 3'b100 : 3'b000)
        : ptr[1] ? (req[0] ? 3'b001 : req[2] ? 3'b100 : req[1] ? 3'b010 : 3'b000)
        :          (req[2] ? 3'b100 : req[1] ? 3'b010 : req[0] ? 3'b001 : 3'b000);
`else
  always_comb
    win = req[2] ? 3'b100 : req[1] ? 3'b010 : req[0] ? 3'b001 : 3'b000;
`endif
  assign sel_we    = win[2] ? uc_we : (win[1] & dc_we);
  assign sel_addr  = win[2] ? uc_addr : win[1] ? dc_addr : ic_addr;
  assign sel_wdata = win[2] ? uc_wdata : win[1] ? dc_wdata : ic_wdata;
  assign sel_wsel  = win[2] ? uc_wsel : win[1] ? dc_wsel : ic_wsel;
  assign ic_done = (state == DONE) & grant[0];
  assign dc_done = (state == DONE) & grant[1];
  assign uc_done = (state == DONE) & grant[2];
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      cnt       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      bus_e     <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wsel  <= '0;
`ifdef ARB_RR_EN
      ptr       <= 3'b001;
`endif
    end else begin
      case (state)
        IDLE: if (|win) begin
          grant     <= win;
          bus_e     <= 1'b1;
          bus_we    <= sel_we;
          bus_addr  <= sel_addr;
          bus_wdata <= sel_wdata;
          bus_wsel  <= sel_wsel;
          cnt       <= '0;
          state     <= BUSY;
`ifdef ARB_RR_EN
          ptr       <= win;
`endif
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (bus_done) begin
            rdata <= bus_rdata;
            err   <= 1'b0;
            bus_e <= 1'b0;
            state <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rdata <= '0;
            err   <= 1'b1;
            bus_e <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
